// File: rtl/l2_core_arbiter_pkg.sv
// Shared system definitions for the L2 core arbiter: FSM state, captured request
// layout and core-count constants.
package sys_defs;

    localparam int NUM_CORES    = 4;
    localparam int ADDR_BITS    = 32;
    localparam int LINE_BITS    = 64;
    localparam int CORE_ID_BITS = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_BITS-1:0]    addr;
        logic                    write;
        logic [LINE_BITS-1:0]    data;
        logic [CORE_ID_BITS-1:0] core;
    } l2_req_t;

    function automatic logic [NUM_CORES-1:0] core_onehot(input logic [CORE_ID_BITS-1:0] idx);
        logic [NUM_CORES-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/l2_core_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or above the pointer,
// wrapping modulo N (N must be a power of two).
module rr_priority_picker #(
    parameter int N       = 4,
    parameter int ID_BITS = $clog2(N)
) (
    input  logic [N-1:0]       req,
    input  logic [ID_BITS-1:0] ptr,
    output logic [N-1:0]       grant,
    output logic [ID_BITS-1:0] idx,
    output logic               any
);

    logic [ID_BITS-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // Truncation to ID_BITS gives the wrap-around for free.
            cand = ID_BITS'(int'(ptr) + k);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_core_arbiter.sv
// Round-robin arbiter sharing one L2 request port among NUM_CORES L1 caches,
// with a single outstanding transaction and response routing back to the requester.
module l2_core_arbiter #(
    parameter int NUM_CORES    = 4,
    parameter int ADDR_BITS    = 32,
    parameter int LINE_BITS    = 64,
    parameter int CORE_ID_BITS = $clog2(NUM_CORES)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CORES-1:0]           req_valid,
    input  logic [NUM_CORES*ADDR_BITS-1:0] req_addr,
    input  logic [NUM_CORES-1:0]           req_write,
    input  logic [NUM_CORES*LINE_BITS-1:0] req_data,
    output logic [NUM_CORES-1:0]           req_ready,
    output logic [NUM_CORES-1:0]           resp_valid,
    output logic [LINE_BITS-1:0]           resp_data,
    output logic                           l2_req_valid,
    input  logic                           l2_req_ready,
    output logic [ADDR_BITS-1:0]           l2_req_addr,
    output logic                           l2_req_write,
    output logic [LINE_BITS-1:0]           l2_req_data,
    output logic [CORE_ID_BITS-1:0]        l2_req_core,
    input  logic                           l2_resp_valid,
    input  logic [LINE_BITS-1:0]           l2_resp_data,
    output logic                           proto_err
);

    import sys_defs::*;

    arb_state_e              state_q, state_d;
    logic [CORE_ID_BITS-1:0] ptr_q, ptr_d;
    l2_req_t                 cap_q, cap_d;
    logic [NUM_CORES-1:0]    resp_valid_q, resp_valid_d;
    logic [LINE_BITS-1:0]    resp_data_q, resp_data_d;
    logic                    proto_err_q, proto_err_d;

    logic [NUM_CORES-1:0]    pick_grant;
    logic [CORE_ID_BITS-1:0] pick_idx;
    logic                    pick_any;

    rr_priority_picker #(
        .N       (NUM_CORES),
        .ID_BITS (CORE_ID_BITS)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cap_d        = cap_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        proto_err_d  = proto_err_q;
        req_ready    = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready   = pick_grant;
                    cap_d.addr  = req_addr[pick_idx*ADDR_BITS +: ADDR_BITS];
                    cap_d.write = req_write[pick_idx];
                    cap_d.data  = req_data[pick_idx*LINE_BITS +: LINE_BITS];
                    cap_d.core  = pick_idx;
                    ptr_d       = pick_idx + 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (l2_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (l2_resp_valid) begin
                    resp_valid_d = core_onehot(cap_q.core);
                    resp_data_d  = l2_resp_data;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A response with no transaction awaiting it is a protocol violation.
        if (l2_resp_valid && (state_q != WAIT)) begin
            proto_err_d = 1'b1;
        end

        if (reset) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cap_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cap_q        <= cap_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign l2_req_valid = (state_q == ISSUE);
    assign l2_req_addr  = cap_q.addr;
    assign l2_req_write = cap_q.write;
    assign l2_req_data  = cap_q.data;
    assign l2_req_core  = cap_q.core;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign proto_err    = proto_err_q;

endmodule

// File: doc/l2_core_arbiter.md
Name: l2_core_arbiter

Overview:
- Shares the single L2 cache request port between NUM_CORES private L1 caches in the multicore system.
- Arbitration is round-robin, with one outstanding transaction at a time.
- Captures the winning L1 request, presents it to the L2 with a valid/ready handshake, and waits for the L2 response. It then routes that response back to the originating core only.
- Sits between the per-core L1 miss/writeback interfaces and the L2 cache's entry/exit packet port.

Parameters:
- NUM_CORES, 4, number of L1 requesters (power of two, 2..8)
- ADDR_BITS, 32, request address width
- LINE_BITS, 64, cache-line data width carried per request and response
- CORE_ID_BITS, $clog2(NUM_CORES), width of the core index

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_CORES  per-core request pending
- req_addr  in  NUM_CORES*ADDR_BITS  per-core request address
- req_write  in  NUM_CORES  per-core request type (1 = writeback, 0 = read)
- req_data  in  NUM_CORES*LINE_BITS  per-core write data
- req_ready  out  NUM_CORES  one-hot pulse: this core's request was captured
- resp_valid  out  NUM_CORES  one-hot pulse: response for this core
- resp_data  out  LINE_BITS  response line data (meaningful only with resp_valid)
- l2_req_valid  out  1  request to L2 valid
- l2_req_ready  in  1  L2 accepts request
- l2_req_addr  out  ADDR_BITS  captured address
- l2_req_write  out  1  captured type
- l2_req_data  out  LINE_BITS  captured write data
- l2_req_core  out  CORE_ID_BITS  captured requester index
- l2_resp_valid  in  1  L2 response (read data, or write acknowledge)
- l2_resp_data  in  LINE_BITS  L2 response data
- proto_err  out  1  sticky flag: unexpected L2 response seen

Behaviour:
- Clocking:
  - Single clock domain.
  - Reset is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - FSM = IDLE.
  - Round-robin pointer = 0.
  - Capture registers are cleared.
- FSM, state IDLE:
  - Winner = first asserted req_valid[i] searching from the pointer upward, with wrap-around modulo NUM_CORES.
  - If a winner exists:
    - Register addr, write, data and core index for the winner.
    - Drive req_ready[winner] = 1 combinationally in this cycle (one cycle only).
    - pointer <= winner + 1 (mod NUM_CORES).
    - Next state = ISSUE.
  - With no req_valid: remain in IDLE; the pointer is unchanged.
- FSM, state ISSUE:
  - l2_req_valid = 1, driven from the capture registers.
  - These values are held stable until l2_req_ready = 1 in ISSUE. That cycle is the handshake; next state = WAIT.
- FSM, state WAIT:
  - l2_req_valid = 0.
  - On l2_resp_valid = 1:
    - resp_valid[captured core] <= 1 and resp_data <= l2_resp_data. Both are registered and visible the next cycle for exactly one cycle.
    - Next state = IDLE.
- Latency:
  - Core request captured in IDLE at cycle t.
  - l2_req_valid asserted at t+1.
  - Earliest response to the core is 1 cycle after l2_resp_valid.
  - Minimum turnaround is 3 cycles plus the L2 latency. Back-to-back grants: the cycle resp_valid is asserted is an IDLE cycle and may capture a new request.
- Writebacks:
  - Follow the same flow.
  - The L2 acknowledges with l2_resp_valid; resp_data is don't-care.
- Fairness:
  - A continuously requesting core is granted at least once per NUM_CORES grants.
  - A core is never granted twice in a row while another core is requesting.
- Request persistence:
  - req_valid/addr/data must be held by the core until req_ready.
  - Deassertion before the grant is legal (the request is simply withdrawn).
- Error handling:
  - l2_resp_valid in IDLE or ISSUE is ignored for routing and sets proto_err.
  - proto_err clears only on reset.
- Simultaneous events:
  - l2_req_ready outside ISSUE is ignored.
- Reset mid-operation:
  - The outstanding transaction is abandoned with no response to the core.
  - The pointer returns to 0.

Decomposition:
- Shared package (sys_defs) holds:
  - a typedef for the arbiter FSM state enum (IDLE, ISSUE, WAIT)
  - a packed request struct {addr, write, data, core}
  - NUM_CORES as a system constant
- Natural sub-module: rr_priority_picker.
  - Combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, index and any-valid.
  - Reusable for the later DRAM read/write channel arbiter.

Test Plan:
- Reset, then a single read. Stimulus: core 2 with addr 0x0000_1040, L2 ready immediately, response 0x00DE_ADBE_EF00_1234 three cycles later. Required:
  - req_ready = 0100 in cycle 0.
  - l2_req_valid in cycle 1 with l2_req_core = 2.
  - resp_valid = 0100 one cycle after l2_resp_valid, with matching data.
  - Other resp_valid bits stay 0.
- All 4 cores request continuously, pointer starts at 0. Required:
  - Grant order 0,1,2,3,0.
  - No core granted twice before all the others are granted once.
- Backpressure. Stimulus: l2_req_ready held low for 5 cycles. Required: l2_req_valid, addr, data and core are stable for all 5 cycles; the handshake completes on the 6th; no further req_ready pulses meanwhile.
- Writeback from core 3. Stimulus: data 0xFFFF_0000_FFFF_0000, addr 0x8000_0000. Required:
  - l2_req_write = 1 with the data intact.
  - Ack is routed to core 3 only.
- Unexpected response. Stimulus: l2_resp_valid pulse while in IDLE. Required:
  - proto_err = 1 and stays 1.
  - No resp_valid asserted.
  - proto_err is cleared only by reset.
- Reset asserted in WAIT. Required:
  - All outputs are 0 the next cycle.
  - A later l2_resp_valid produces no resp_valid.
  - The next grant searches from core 0.
